uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command sequencer between the UART receiver and the ADC/temperature-sensor control logic. Consumes the received byte stream (`rdata`/`vld` from the UART receiver), parses fixed-length command frames, and either writes an internal bank of 8-bit configuration registers or issues a one-cycle conversion-start pulse. Malformed, timed-out or invalid frames are discarded and flagged; configuration state is never partially updated.

## Interface
- `FREQ`, 50_000_000, clock frequency in Hz (documentation only; timeout is in cycles)
- `N_REG`, 8, number of configuration registers (1..16)
- `TIMEOUT_CYC`, 50_000, max idle cycles between bytes inside a frame (≥2)
- `clk` input 1: system clock, all logic on rising edge
- `nrst` input 1: asynchronous, active-low reset
- `rx_data` input 8: received byte, valid only when `rx_vld`=1
- `rx_vld` input 1: one-cycle strobe per received byte
- `cfg_regs` output 8*N_REG: flat register bank, reg i at bits [8i+7:8i]
- `start_pulse` output 1: one-cycle conversion start
- `ack` output 1: one-cycle pulse per successfully executed frame
- `frame_err` output 1: one-cycle pulse per rejected frame
- `busy` output 1: high whenever the FSM is not in IDLE

## Operation
- Frame: `0xA5`, CMD, ADDR, DATA, then CSUM when `UART_CMD_CSUM_EN` is defined
- CMD `0x01`: write DATA to register ADDR. CMD `0x02`: assert `start_pulse`; ADDR/DATA ignored. CMD `0x03`: clear all registers to 0; ADDR/DATA ignored
- FSM states: IDLE, CMD, ADDR, DATA, CSUM (only with macro), EXEC
- IDLE: `rx_vld` with `0xA5` goes to CMD. Any other byte is dropped silently, with no `frame_err`
- CMD→ADDR→DATA→(CSUM)→EXEC: advance on each `rx_vld` and latch the byte
- Validity is checked when entering EXEC:
  - CMD must be in {01,02,03}
  - For CMD 01, ADDR must be < N_REG
  - Checksum must match when enabled
- EXEC (one cycle): on a valid frame, perform the action and pulse `ack`. On an invalid frame, pulse `frame_err` with no register change. Return to IDLE either way
- `rx_vld` arriving while in EXEC is dropped. The next `0xA5` is recognised only from IDLE
- Timeout:
  - A 32-bit gap counter clears on each accepted byte and counts every cycle in CMD/ADDR/DATA/CSUM
  - When it reaches TIMEOUT_CYC-1 with no `rx_vld` that cycle: pulse `frame_err` and go to IDLE
  - If `rx_vld` coincides with the terminal count, the byte wins and there is no timeout
- `0xA5` received mid-frame is treated as ordinary data; there is no resynchronisation

## Timing
- Reset values: `cfg_regs`=0, `start_pulse`=0, `ack`=0, `frame_err`=0, `busy`=0, FSM in IDLE, gap counter=0
- Final byte sampled at edge E gives EXEC during cycle E→E+1. `cfg_regs` update, `start_pulse`, and `ack`/`frame_err` are all registered at edge E+1 and high for exactly one cycle (pulses)
- `busy` rises one edge after the `0xA5` strobe and falls at the same edge that `ack`/`frame_err` rises
- `start_pulse` and `ack` rise together for CMD 02
- Reset asserted mid-frame aborts immediately with no pulse. `cfg_regs` returns to 0

## Configuration
- `UART_CMD_CSUM_EN` defined:
  - 5-byte frames including the CSUM state
  - CSUM must equal CMD ^ ADDR ^ DATA; a mismatch gives `frame_err`
- Not defined:
  - 4-byte frames with no CSUM state
  - EXEC entered on the DATA byte

## Test plan
- Reset, then frame A5 01 03 5C (+CSUM 5E when enabled) → reg3=0x5C one cycle after last strobe, `ack`=1 for 1 cycle, other regs 0
- Frame A5 02 00 00 (+CSUM 02) → `start_pulse` and `ack` high for exactly one cycle, `cfg_regs` unchanged
- Frame A5 01 08 11 with N_REG=8 and frame A5 07 00 00 → `frame_err` pulse each, no register change. With macro enabled, A5 01 02 33 CSUM 00 → `frame_err`
- Bytes 12 34 then A5 01 00 AA (+CSUM AB) → leading bytes ignored with no `frame_err`, reg0=0xAA, `ack` pulse
- A5 01, then silence for TIMEOUT_CYC cycles → `frame_err` pulse, `busy` low. A following complete valid frame executes normally
- nrst low after A5 01 02 → all outputs 0. After release, A5 03 00 00 (+CSUM 03) following writes clears all regs and gives `ack`

Source files
------------

// File: rtl/uart_cmd_if.sv
// uart_cmd_if: received-byte stream from the UART receiver into the command sequencer.
interface uart_cmd_if;
  logic [7:0] rx_data;
  logic       rx_vld;
  modport master (output rx_data, rx_vld);
  modport slave (input rx_data, rx_vld);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses A5/CMD/ADDR/DATA frames into register writes, clears and start pulses.
// Define UART_CMD_CSUM_EN to append a CSUM byte (CMD^ADDR^DATA) to every frame.
module uart_cmd_ctrl #(
  parameter int FREQ        = 50_000_000,
  parameter int N_REG       = 8,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic               clk,
  input  logic               nrst,
  uart_cmd_if.slave          rx,
  output logic [8*N_REG-1:0] cfg_regs,
  output logic               start_pulse,
  output logic               ack,
  output logic               frame_err,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CSUM, EXEC} state_t;
  if (N_REG < 1 || N_REG > 16 || TIMEOUT_CYC < 2 || FREQ < 1) begin : g_param_check
    $error("uart_cmd_ctrl: parameter out of range");
  end
  state_t      state;
  logic [7:0]  cmd_q, addr_q, data_q;
  logic [31:0] gap;
  logic        frame_ok;
`ifdef UART_CMD_CSUM_EN
  logic [7:0] csum_q;
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = EXEC;
`endif
  always_comb begin
    frame_ok = (cmd_q == 8'h01 && 32'(addr_q) < N_REG) || cmd_q == 8'h02 || cmd_q == 8'h03;
`ifdef UART_CMD_CSUM_EN
    frame_ok = frame_ok && csum_q == (cmd_q ^ addr_q ^ data_q);
`endif
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
`ifdef UART_CMD_CSUM_EN
      csum_q      <= '0;
`endif
      gap         <= '0;
      cfg_regs    <= '0;
      start_pulse <= 1'b0;
      ack         <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      ack         <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: if (rx.rx_vld && rx.rx_data == 8'hA5) begin
          state <= CMD;
          busy  <= 1'b1;
          gap   <= '0;
        end
        EXEC: begin
          state       <= IDLE;
          busy        <= 1'b0;
          gap         <= '0;
          ack         <= frame_ok;
          frame_err   <= !frame_ok;
          start_pulse <= frame_ok && cmd_q == 8'h02;
          if (frame_ok && cmd_q == 8'h03) cfg_regs <= '0;
          for (int i = 0; i < N_REG; i++)
            if (frame_ok && cmd_q == 8'h01 && addr_q == 8'(i)) cfg_regs[8*i +: 8] <= data_q;
        end
        default: if (rx.rx_vld) begin
          gap <= '0;
          case (state)
            CMD:  begin cmd_q  <= rx.rx_data; state <= ADDR; end
            ADDR: begin addr_q <= rx.rx_data; state <= DATA; end
            DATA: begin data_q <= rx.rx_data; state <= AFTER_DATA; end
`ifdef UART_CMD_CSUM_EN
            default: begin csum_q <= rx.rx_data; state <= EXEC; end
`else
            default: state <= IDLE;
`endif
          endcase
        end else if (gap == 32'(TIMEOUT_CYC - 1)) begin
          // a byte landing on the terminal count takes priority over the timeout
          state     <= IDLE;
          busy      <= 1'b0;
          frame_err <= 1'b1;
          gap       <= '0;
        end else gap <= gap + 32'd1;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: random and directed frames checked against a byte-level frame model.
module tb_uart_cmd_ctrl;
  localparam int N_REG = 8;
  localparam int TO    = 20;
`ifdef UART_CMD_CSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif
  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic [8*N_REG-1:0] cfg_regs;
  logic               start_pulse, ack, frame_err, busy;
  logic [7:0]         ref_regs [N_REG];
  int                 checks = 0;
  int                 errors = 0;
  uart_cmd_if bus ();
  uart_cmd_ctrl #(.N_REG(N_REG), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .nrst(nrst), .rx(bus), .cfg_regs(cfg_regs),
    .start_pulse(start_pulse), .ack(ack), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [8*N_REG-1:0] got, input logic [8*N_REG-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8*N_REG-1:0] ref_flat();
    logic [8*N_REG-1:0] f;
    for (int i = 0; i < N_REG; i++) f[8*i +: 8] = ref_regs[i];
    return f;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    tick();
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask
  function automatic int rand_gap();
    return ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, 4));
  endfunction
  task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] s, input bit exec_a5);
    logic [7:0] fr [5];
    bit ok;
    fr = '{8'hA5, c, a, d, s};
    ok = (c == 8'h01 && int'(a) < N_REG) || c == 8'h02 || c == 8'h03;
`ifdef UART_CMD_CSUM_EN
    ok = ok && s == (c ^ a ^ d);
`endif
    for (int i = 0; i < FL; i++) begin
      strobe(fr[i]);
      if (i == 0) chk("busy_rise", busy, 1);
      if (i < FL - 1) repeat (rand_gap()) tick();
    end
    chk("busy_exec", busy, 1);
    chk("no_early_ack", ack, 0);
    if (exec_a5) begin
      bus.rx_data = 8'hA5;
      bus.rx_vld  = 1'b1;
    end
    tick();
    bus.rx_vld = 1'b0;
    if (ok && c == 8'h01) ref_regs[a[2:0]] = d;
    if (ok && c == 8'h03) foreach (ref_regs[i]) ref_regs[i] = 8'h00;
    chk("ack", ack, ok);
    chk("frame_err", frame_err, !ok);
    chk("start_pulse", start_pulse, ok && c == 8'h02);
    chk("cfg_regs", cfg_regs, ref_flat());
    chk("busy_fall", busy, 0);
    tick();
    chk("pulse_width", {ack, frame_err, start_pulse}, 0);
    chk("exec_byte_dropped", busy, 0);
  endtask
  task automatic junk(input logic [7:0] b);
    strobe(b == 8'hA5 ? 8'h12 : b);
    chk("junk_no_err", frame_err, 0);
    chk("junk_idle", busy, 0);
  endtask
  task automatic timeout_after(input int k);
    strobe(8'hA5);
    for (int i = 1; i < k; i++) begin
      repeat (rand_gap()) tick();
      strobe(8'($urandom));
    end
    repeat (TO - 1) tick();
    chk("to_not_yet", frame_err, 0);
    chk("to_busy", busy, 1);
    tick();
    chk("to_err", frame_err, 1);
    chk("to_idle", busy, 0);
    chk("to_no_ack", ack, 0);
    tick();
    chk("to_width", frame_err, 0);
  endtask
  initial begin
    logic [7:0] c, a, d, s;
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
    foreach (ref_regs[i]) ref_regs[i] = 8'h00;
    repeat (2) tick();
    chk("rst_cfg", cfg_regs, 0);
    chk("rst_pulses", {start_pulse, ack, frame_err, busy}, 0);
    nrst = 1'b1;
    tick();
    run_frame(8'h01, 8'h03, 8'h5C, 8'h5E, 0);
    run_frame(8'h02, 8'h00, 8'h00, 8'h02, 0);
    run_frame(8'h01, 8'h08, 8'h11, 8'h18, 0);
    run_frame(8'h07, 8'h00, 8'h00, 8'h07, 0);
`ifdef UART_CMD_CSUM_EN
    run_frame(8'h01, 8'h02, 8'h33, 8'h00, 0);
`endif
    junk(8'h12);
    junk(8'h34);
    run_frame(8'h01, 8'h00, 8'hAA, 8'hAB, 1);
    timeout_after(2);
    run_frame(8'h01, 8'h05, 8'h77, 8'h73, 0);
    strobe(8'hA5);
    strobe(8'h01);
    strobe(8'h02);
    nrst = 1'b0;
    #1;
    foreach (ref_regs[i]) ref_regs[i] = 8'h00;
    chk("midrst_cfg", cfg_regs, 0);
    chk("midrst_outs", {start_pulse, ack, frame_err, busy}, 0);
    tick();
    nrst = 1'b1;
    tick();
    run_frame(8'h01, 8'h01, 8'h3C, 8'h3C ^ 8'h01 ^ 8'h01, 0);
    run_frame(8'h01, 8'h07, 8'hE1, 8'hE1 ^ 8'h07 ^ 8'h01, 0);
    run_frame(8'h03, 8'h00, 8'h00, 8'h03, 0);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0: junk(8'($urandom));
        1: timeout_after(int'($urandom_range(1, FL - 1)));
        default: begin
          c = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(1, 3));
          if (c == 8'h03 && $urandom_range(0, 2) != 0) c = 8'h01;
          a = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, N_REG + 1));
          d = 8'($urandom);
          s = ($urandom_range(0, 5) == 0) ? 8'($urandom) : c ^ a ^ d;
          run_frame(c, a, d, s, $urandom_range(0, 3) == 0);
        end
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
